// File: rtl/regfile_sb.sv
// Parametrised register file with a per-register write scoreboard for RAW hazard detection.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 2,
  parameter int DBG_REG       = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
  output logic [NUM_READ-1:0]               rd_busy,
  input  logic                              wr_en,
  input  logic [ADDRESS_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              iss_en,
  input  logic [ADDRESS_WIDTH-1:0]          iss_addr,
  input  logic                              flush,
  output logic [DATA_WIDTH-1:0]             dbg_data,
  output logic [ADDRESS_WIDTH:0]            pending_cnt
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] DBG_IDX = ADDRESS_WIDTH'(DBG_REG);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      sb;
  logic [DEPTH-1:0]      sb_next;
  logic                  wr_live;
  logic                  iss_live;

  assign wr_live  = wr_en && (wr_addr != '0);
  assign iss_live = iss_en && (iss_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Later assignments win: write clears, a same-address issue re-marks, flush wipes everything.
  always_comb begin
    sb_next = sb;
    if (wr_live)  sb_next[wr_addr]  = 1'b0;
    if (iss_live) sb_next[iss_addr] = 1'b1;
    if (flush)    sb_next           = '0;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb <= '0;
    else        sb <= sb_next;
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    stored;
    assign addr   = rd_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign stored = (addr == '0) ? '0 : regs[addr];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated by rst_n so outputs read zero during reset even with wr_en high.
    logic hit;
    logic iss_same;
    assign hit      = rst_n && wr_live && (addr == wr_addr);
    assign iss_same = iss_live && (iss_addr == addr);
    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = hit ? wr_data : stored;
    assign rd_busy[p] = (hit && !iss_same) ? 1'b0 : sb[addr];
`else
    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = stored;
    assign rd_busy[p] = sb[addr];
`endif
  end

  assign dbg_data = (DBG_IDX == '0) ? '0 : regs[DBG_IDX];

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < DEPTH; i++) pending_cnt = pending_cnt + (ADDRESS_WIDTH + 1)'(sb[i]);
  end

endmodule
